// File: rtl/mrc_ec_pkg.sv
// Shared types and constants for the skip-3 result collector.
// Sign codes, default latencies and tap latency helper.
package mrc_ec_pkg;

  localparam logic [1:0] SGN_ZERO = 2'b00;
  localparam logic [1:0] SGN_POS  = 2'b01;
  localparam logic [1:0] SGN_NEG  = 2'b10;
  localparam logic [1:0] SGN_INV  = 2'b11;

  localparam int STAGE_LAT_DEF = 8;
  localparam int CMP_LAT_DEF   = 9;
  localparam int DATA_W_DEF    = 18;
  localparam int TAG_W_DEF     = 8;

  // Tap index 0 selects the d3_0_8_ value tap.
  localparam int TAP_D = 0;

  // Latency of tap k (4..9, or TAP_D) after the in_valid cycle.
  function automatic int tap_lat(input int k, input int sl, input int cl);
    int r;
    if (k == TAP_D)
      r = 6 * sl;
    else if (k == 9)
      r = cl + 6 * sl;
    else
      r = cl + (k - 4) * sl;
    return r;
  endfunction

  typedef struct packed {
    logic [DATA_W_DEF-1:0] value;
    logic [1:0]            sign;
    logic                  err;
    logic [11:0]           hist;
    logic [TAG_W_DEF-1:0]  tag;
  } res_t;

endpackage

// File: rtl/mrc_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered state only.
// A push into a full FIFO is taken when a pop happens the same cycle.
module mrc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rp[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // Storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mrc_ec_skp3_collect.sv
// Re-aligns skip-3 pipeline taps into one result, classifies it,
// counts errors/drops and buffers results in an output FIFO.
module mrc_ec_skp3_collect
  import mrc_ec_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int TAG_WIDTH  = 8,
  parameter int STAGE_LAT  = 8,
  parameter int CMP_LAT    = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [DATA_WIDTH-1:0] d3_0_8_,
  input  logic [1:0]            Sgn_out_4_,
  input  logic [1:0]            Sgn_out_5_,
  input  logic [1:0]            Sgn_out_6_,
  input  logic [1:0]            Sgn_out_7_,
  input  logic [1:0]            Sgn_out_8_A,
  input  logic [1:0]            Sgn_out_8_B,
  input  logic [1:0]            Sgn_out_9_A,
  input  logic [1:0]            Sgn_out_9_B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic [1:0]            out_sign,
  output logic                  out_err,
  output logic [11:0]           out_sgn_hist,
  output logic [TAG_WIDTH-1:0]  out_tag,
  input  logic                  cnt_clr,
  output logic [15:0]           err_cnt,
  output logic [15:0]           drop_cnt,
  output logic                  ovf
);

  localparam int L9 = tap_lat(9, STAGE_LAT, CMP_LAT);
  localparam int D4 = L9 - tap_lat(4, STAGE_LAT, CMP_LAT);
  localparam int D5 = L9 - tap_lat(5, STAGE_LAT, CMP_LAT);
  localparam int D6 = L9 - tap_lat(6, STAGE_LAT, CMP_LAT);
  localparam int D7 = L9 - tap_lat(7, STAGE_LAT, CMP_LAT);
  localparam int D8 = L9 - tap_lat(8, STAGE_LAT, CMP_LAT);
  localparam int DD = L9 - tap_lat(TAP_D, STAGE_LAT, CMP_LAT);
  localparam int EW = DATA_WIDTH + 2 + 1 + 12 + TAG_WIDTH;

  logic [L9-1:0]         v_dl;
  logic [TAG_WIDTH-1:0]  tag_dl [L9];
  logic [1:0]            s4_dl  [D4];
  logic [1:0]            s5_dl  [D5];
  logic [1:0]            s6_dl  [D6];
  logic [1:0]            s7_dl  [D7];
  logic [3:0]            s8_dl  [D8];
  logic [DATA_WIDTH-1:0] d_dl   [DD];

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          drop;
  logic          err;
  logic [1:0]    sign;
  logic [1:0]    s8a;
  logic [1:0]    s8b;
  logic [11:0]   hist;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  // Valid delay line; reset discards in-flight transactions
  always_ff @(posedge clk) begin
    if (rst) v_dl <= '0;
    else     v_dl <= {v_dl[L9-2:0], in_valid};
  end

  // Data delay lines, no reset needed
  always_ff @(posedge clk) begin
    tag_dl[0] <= in_tag;
    s4_dl[0]  <= Sgn_out_4_;
    s5_dl[0]  <= Sgn_out_5_;
    s6_dl[0]  <= Sgn_out_6_;
    s7_dl[0]  <= Sgn_out_7_;
    s8_dl[0]  <= {Sgn_out_8_A, Sgn_out_8_B};
    d_dl[0]   <= d3_0_8_;
    for (int i = 1; i < L9; i++) tag_dl[i] <= tag_dl[i-1];
    for (int i = 1; i < D4; i++) s4_dl[i]  <= s4_dl[i-1];
    for (int i = 1; i < D5; i++) s5_dl[i]  <= s5_dl[i-1];
    for (int i = 1; i < D6; i++) s6_dl[i]  <= s6_dl[i-1];
    for (int i = 1; i < D7; i++) s7_dl[i]  <= s7_dl[i-1];
    for (int i = 1; i < D8; i++) s8_dl[i]  <= s8_dl[i-1];
    for (int i = 1; i < DD; i++) d_dl[i]   <= d_dl[i-1];
  end

  assign {s8a, s8b} = s8_dl[D8-1];

  // Classify the aligned result
  always_comb begin
    err  = (Sgn_out_9_A != Sgn_out_9_B) ||
           (Sgn_out_9_A == SGN_INV) ||
           (s8a != s8b);
    sign = err ? SGN_INV : Sgn_out_9_A;
    hist = {s4_dl[D4-1], s5_dl[D5-1], s6_dl[D6-1],
            s7_dl[D7-1], s8a, s8b};
  end

  assign push  = v_dl[L9-1];
  assign pop   = out_valid & out_ready;
  assign drop  = push & full & ~pop;
  assign wdata = {d_dl[DD-1], sign, err, hist, tag_dl[L9-1]};

  mrc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign {out_value, out_sign, out_err,
          out_sgn_hist, out_tag} = rdata;

  // Saturating error/drop counters and sticky overflow
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_cnt  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push && err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (drop)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mrc_ec_skp3_collect.sv
// Directed bench for mrc_ec_skp3_collect.
// Taps are replayed from a cycle-indexed ring at their latencies.
module tb_mrc_ec_skp3_collect;
  import mrc_ec_pkg::*;

  typedef struct packed {
    logic        v;
    logic [7:0]  tag;
    logic [17:0] val;
    logic [1:0]  s4, s5, s6, s7, s8a, s8b, s9a, s9b;
  } tx_t;

  typedef struct {
    res_t r;
    int   c;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_tag = '0;
  logic [17:0] d3_0_8_ = '0;
  logic [1:0]  Sgn_out_4_ = '0, Sgn_out_5_ = '0;
  logic [1:0]  Sgn_out_6_ = '0, Sgn_out_7_ = '0;
  logic [1:0]  Sgn_out_8_A = '0, Sgn_out_8_B = '0;
  logic [1:0]  Sgn_out_9_A = '0, Sgn_out_9_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [17:0] out_value;
  logic [1:0]  out_sign;
  logic        out_err;
  logic [11:0] out_sgn_hist;
  logic [7:0]  out_tag;
  logic        cnt_clr = 1'b0;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;
  logic        ovf;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  tx_t  ring [128];
  obs_t obs [$];

  mrc_ec_skp3_collect dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_tag       (in_tag),
    .d3_0_8_      (d3_0_8_),
    .Sgn_out_4_   (Sgn_out_4_),
    .Sgn_out_5_   (Sgn_out_5_),
    .Sgn_out_6_   (Sgn_out_6_),
    .Sgn_out_7_   (Sgn_out_7_),
    .Sgn_out_8_A  (Sgn_out_8_A),
    .Sgn_out_8_B  (Sgn_out_8_B),
    .Sgn_out_9_A  (Sgn_out_9_A),
    .Sgn_out_9_B  (Sgn_out_9_B),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_value    (out_value),
    .out_sign     (out_sign),
    .out_err      (out_err),
    .out_sgn_hist (out_sgn_hist),
    .out_tag      (out_tag),
    .cnt_clr      (cnt_clr),
    .err_cnt      (err_cnt),
    .drop_cnt     (drop_cnt),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Replay each tap from the transaction issued its latency ago
  always @(negedge clk) begin
    Sgn_out_4_  = ring[7'(cyc - 9)].s4;
    Sgn_out_5_  = ring[7'(cyc - 17)].s5;
    Sgn_out_6_  = ring[7'(cyc - 25)].s6;
    Sgn_out_7_  = ring[7'(cyc - 33)].s7;
    Sgn_out_8_A = ring[7'(cyc - 41)].s8a;
    Sgn_out_8_B = ring[7'(cyc - 41)].s8b;
    Sgn_out_9_A = ring[7'(cyc - 57)].s9a;
    Sgn_out_9_B = ring[7'(cyc - 57)].s9b;
    d3_0_8_     = ring[7'(cyc - 48)].val;
  end

  // Record every accepted head, sampled mid-cycle
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) begin
      obs_t o;
      o.r = '{value: out_value, sign: out_sign, err: out_err,
              hist: out_sgn_hist, tag: out_tag};
      o.c = cyc;
      obs.push_back(o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic tx_t mk(
    input logic [7:0] tag, input logic [17:0] val,
    input logic [1:0] s4, s5, s6, s7,
    input logic [1:0] s8a, s8b, s9a, s9b);
    tx_t x;
    x = '{v: 1'b1, tag: tag, val: val, s4: s4, s5: s5,
          s6: s6, s7: s7, s8a: s8a, s8b: s8b,
          s9a: s9a, s9b: s9b};
    return x;
  endfunction

  task automatic drive(input tx_t x, input logic r);
    in_valid  = x.v;
    in_tag    = x.tag;
    out_ready = r;
    ring[cyc[6:0]] = x;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive('0, r);
  endtask

  task automatic chk_obs(input string nm, input int idx,
                         input res_t e);
    chk({nm, "_present"}, 64'(obs.size() > idx), 64'd1);
    if (obs.size() > idx) begin
      chk({nm, "_value"}, 64'(obs[idx].r.value), 64'(e.value));
      chk({nm, "_sign"},  64'(obs[idx].r.sign),  64'(e.sign));
      chk({nm, "_err"},   64'(obs[idx].r.err),   64'(e.err));
      chk({nm, "_hist"},  64'(obs[idx].r.hist),  64'(e.hist));
      chk({nm, "_tag"},   64'(obs[idx].r.tag),   64'(e.tag));
    end
  endtask

  initial begin
    int   base;
    int   c0;
    tx_t  x;
    res_t e;
    for (int i = 0; i < 128; i++) ring[i] = '0;

    // Reset, then idle until cycle 10
    @(negedge clk);
    while (cyc < 3) idle(1, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    idle(1, 1'b1);
    chk("rst_value", 64'(out_value), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_hist", 64'(out_sgn_hist), 64'd0);
    chk("rst_sign_err", 64'({out_sign, out_err}), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    while (cyc < 10) idle(1, 1'b1);

    // Single legal value, in_valid in cycle 10
    drive(mk(8'h5A, 18'd12345, 1, 1, 1, 1, 1, 1, 1, 1), 1'b1);
    idle(62, 1'b1);
    chk("single_count", 64'(obs.size()), 64'd1);
    chk_obs("single", 0, '{value: 18'd12345, sign: 2'b01,
            err: 1'b0, hist: 12'h555, tag: 8'h5A});
    if (obs.size() > 0)
      chk("single_cycle", 64'(obs[0].c), 64'd68);
    chk("single_err_cnt", 64'(err_cnt), 64'd0);

    // Sgn9 mismatch
    drive(mk(8'h61, 18'd777, 1, 1, 1, 1, 1, 1, 1, 2), 1'b1);
    idle(62, 1'b1);
    chk_obs("err9", 1, '{value: 18'd777, sign: 2'b11,
            err: 1'b1, hist: 12'h555, tag: 8'h61});
    chk("err9_cnt", 64'(err_cnt), 64'd1);

    // Sgn8 mismatch only
    drive(mk(8'h62, 18'd778, 1, 1, 1, 1, 1, 2, 2, 2), 1'b1);
    idle(62, 1'b1);
    chk_obs("err8", 2, '{value: 18'd778, sign: 2'b11,
            err: 1'b1, hist: 12'h556, tag: 8'h62});
    chk("err8_cnt", 64'(err_cnt), 64'd2);

    // Sgn9 both invalid
    drive(mk(8'h63, 18'd779, 0, 0, 0, 0, 0, 0, 3, 3), 1'b1);
    idle(62, 1'b1);
    chk_obs("errinv", 3, '{value: 18'd779, sign: 2'b11,
            err: 1'b1, hist: 12'h000, tag: 8'h63});
    chk("errinv_cnt", 64'(err_cnt), 64'd3);

    // 20 back-to-back legal transactions
    base = obs.size();
    for (int i = 0; i < 20; i++) begin
      x = mk(8'(8'h80 + i), 18'(5000 + i * 37),
             2'(i), 2'(i + 1), 2'(i + 2), 2'(i + 3),
             2'(i % 3), 2'(i % 3), 2'((i + 1) % 3), 2'((i + 1) % 3));
      drive(x, 1'b1);
    end
    idle(62, 1'b1);
    chk("b2b_count", 64'(obs.size() - base), 64'd20);
    c0 = (obs.size() > base) ? obs[base].c : 0;
    for (int i = 0; i < 20; i++) begin
      e.value = 18'(5000 + i * 37);
      e.sign  = 2'((i + 1) % 3);
      e.err   = 1'b0;
      e.hist  = {2'(i), 2'(i + 1), 2'(i + 2), 2'(i + 3),
                 2'(i % 3), 2'(i % 3)};
      e.tag   = 8'(8'h80 + i);
      chk_obs($sformatf("b2b%0d", i), base + i, e);
      if (obs.size() > base + i)
        chk($sformatf("b2b%0d_cyc", i), 64'(obs[base + i].c),
            64'(c0 + i));
    end
    chk("b2b_err_cnt", 64'(err_cnt), 64'd3);

    // Overflow: 12 transactions with the consumer stalled
    base = obs.size();
    for (int i = 0; i < 12; i++) begin
      if (i >= 10)
        x = mk(8'(8'h40 + i), 18'(100 + i), 1, 1, 1, 1, 1, 1, 1, 2);
      else
        x = mk(8'(8'h40 + i), 18'(100 + i), 1, 1, 1, 1, 1, 1, 1, 1);
      drive(x, 1'b0);
    end
    idle(61, 1'b0);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_err_cnt", 64'(err_cnt), 64'd5);
    chk("ovf_no_pop", 64'(obs.size() - base), 64'd0);
    chk("ovf_head_valid", 64'(out_valid), 64'd1);
    chk("ovf_head_tag", 64'(out_tag), 64'h40);

    // Push coinciding with a pop while full
    drive(mk(8'h50, 18'd999, 2, 2, 2, 2, 2, 2, 2, 2), 1'b0);
    idle(56, 1'b0);
    idle(1, 1'b1);
    idle(5, 1'b0);
    chk("full_pop_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("full_pop_count", 64'(obs.size() - base), 64'd1);
    idle(12, 1'b1);
    chk("drain_count", 64'(obs.size() - base), 64'd9);
    for (int i = 0; i < 8; i++)
      if (obs.size() > base + i)
        chk($sformatf("drain%0d_tag", i), 64'(obs[base + i].r.tag),
            64'(8'h40 + i));
    chk_obs("drain_last", base + 8, '{value: 18'd999, sign: 2'b10,
            err: 1'b0, hist: 12'hAAA, tag: 8'h50});
    chk("drain_empty_valid", 64'(out_valid), 64'd0);
    chk("drain_empty_value", 64'(out_value), 64'd0);

    // Counter clear
    cnt_clr = 1'b1;
    idle(1, 1'b1);
    cnt_clr = 1'b0;
    idle(1, 1'b1);
    chk("clr_err_cnt", 64'(err_cnt), 64'd0);
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("clr_ovf", 64'(ovf), 64'd0);

    // Reset mid-flight at t+30
    base = obs.size();
    for (int i = 0; i < 5; i++)
      drive(mk(8'(8'h70 + i), 18'(300 + i), 1, 1, 1, 1, 1, 1, 1, 2),
            1'b1);
    idle(25, 1'b1);
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
    idle(70, 1'b1);
    chk("rstmid_no_output", 64'(obs.size() - base), 64'd0);
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_err_cnt", 64'(err_cnt), 64'd0);
    chk("rstmid_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rstmid_ovf", 64'(ovf), 64'd0);

    // Saturation of err_cnt
    for (int i = 0; i < 65535; i++)
      drive(mk(8'(i), 18'(i), 1, 1, 1, 1, 1, 1, 1, 2), 1'b1);
    idle(62, 1'b1);
    chk("sat_err_cnt", 64'(err_cnt), 64'hFFFF);
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 3; i++)
      drive(mk(8'h11, 18'd1, 1, 1, 1, 1, 1, 2, 1, 1), 1'b1);
    idle(62, 1'b1);
    chk("sat_hold", 64'(err_cnt), 64'hFFFF);

    // Clear back to zero, then clear coinciding with an error push
    cnt_clr = 1'b1;
    idle(1, 1'b1);
    cnt_clr = 1'b0;
    drive(mk(8'h22, 18'd2, 1, 1, 1, 1, 1, 1, 1, 2), 1'b1);
    idle(56, 1'b1);
    cnt_clr = 1'b1;
    idle(1, 1'b1);
    cnt_clr = 1'b0;
    idle(3, 1'b1);
    chk("clr_wins", 64'(err_cnt), 64'd0);
    drive(mk(8'h23, 18'd3, 1, 1, 1, 1, 1, 1, 1, 2), 1'b1);
    idle(62, 1'b1);
    chk("after_clr_cnt", 64'(err_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
